// File: rtl/uart_mem_initiator.sv
// uart_mem_initiator: host-side UART initiator for the memory-override protocol.
// A single read/write request is accepted and sent as a 3- or 5-byte command frame on
// o_uart_tx. The reply is collected from i_uart_rx, and o_rsp_valid pulses for one cycle.
// Optional feature: define UART_INIT_TIMEOUT_EN to end a stalled wait after TIMEOUT_CYCLES
// cycles with o_rsp_err set.
//
// state  | meaning
// S_IDLE | ready for a request; received bytes are discarded
// S_SEND | shifting out the command bytes
// S_WAIT | collecting response bytes
// S_DONE | one-cycle response strobe
module uart_mem_initiator #(
    parameter int unsigned DELAY_FRAMES   = 234,
    parameter int unsigned TIMEOUT_CYCLES = 2700000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_uart_rx,
    output logic        o_uart_tx,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_rnw,
    input  logic [15:0] i_req_addr,
    input  logic [15:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [15:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    localparam int unsigned    CNT_W     = $clog2(DELAY_FRAMES);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DELAY_FRAMES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DELAY_FRAMES / 2 - 1);

    if (DELAY_FRAMES < 4 || TIMEOUT_CYCLES == 0) begin : g_bad_param
        $error("uart_mem_initiator: DELAY_FRAMES must be >= 4 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    // transmitter
    logic               r_tx;
    logic [CNT_W-1:0]   r_tx_cnt;
    logic [3:0]         r_tx_bit;     // 0 = start, 1..8 = data, 9 = stop
    logic [2:0]         r_tx_left;    // bytes still to send after the current one
    logic [39:0]        r_cmd;        // current byte in [7:0]
    logic               r_rnw;

    // receiver
    logic               r_rx_s1;
    logic               r_rx_s2;
    logic               r_rx_d;
    logic               r_rx_busy;
    logic [3:0]         r_rx_bit;     // 0 = start check, 1..8 = data, 9 = stop
    logic [CNT_W-1:0]   r_rx_cnt;
    logic [7:0]         r_rx_sr;
    logic [7:0]         r_rx_byte;
    logic               r_rx_done;

    // response
    logic               r_rsp_cnt;
    logic [7:0]         r_rsp_hi;
    logic [15:0]        r_rsp_rdata;
    logic               r_rsp_err;

    logic               w_accept;
    logic               w_tx_tick;
    logic               w_tx_end;
    logic               w_rx_fall;
    logic               w_rsp_last;
    logic               w_timeout;

    assign w_accept   = (r_state == S_IDLE) && i_req_valid;
    assign w_tx_tick  = (r_tx_cnt == '0);
    assign w_tx_end   = (r_state == S_SEND) && w_tx_tick && (r_tx_bit == 4'd9) && (r_tx_left == 3'd0);
    assign w_rx_fall  = !r_rx_s2 && r_rx_d;
    assign w_rsp_last = (r_state == S_WAIT) && r_rx_done && (!r_rnw || r_rsp_cnt);

`ifdef UART_INIT_TIMEOUT_EN
    localparam int unsigned   TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_to_cnt;

    // Response timeout: reloaded on entry to WAIT and on every received byte.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_to_cnt <= '0;
        end else if (w_tx_end || ((r_state == S_WAIT) && r_rx_done)) begin
            r_to_cnt <= TO_LAST;
        end else if ((r_state == S_WAIT) && (r_to_cnt != '0)) begin
            r_to_cnt <= r_to_cnt - 1'b1;
        end
    end

    assign w_timeout = (r_state == S_WAIT) && !r_rx_done && (r_to_cnt == '0);
`else
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and strobe outputs.
    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (w_accept) w_state_nxt = S_SEND;
            end
            S_SEND: if (w_tx_end) w_state_nxt = S_WAIT;
            S_WAIT: if (w_rsp_last || w_timeout) w_state_nxt = S_DONE;
            S_DONE: begin
                o_rsp_valid = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Command serialiser: captures the request and shifts bytes out back-to-back.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tx      <= 1'b1;
            r_tx_cnt  <= '0;
            r_tx_bit  <= '0;
            r_tx_left <= '0;
            r_cmd     <= '0;
            r_rnw     <= 1'b0;
        end else if (w_accept) begin
            r_tx     <= 1'b0;
            r_tx_cnt <= BIT_LAST;
            r_tx_bit <= '0;
            r_rnw    <= i_req_rnw;
            if (i_req_rnw) begin
                r_cmd     <= {16'h0000, i_req_addr[7:0], i_req_addr[15:8], 8'h52};
                r_tx_left <= 3'd2;
            end else begin
                r_cmd     <= {i_req_wdata[7:0], i_req_wdata[15:8], i_req_addr[7:0], i_req_addr[15:8], 8'h57};
                r_tx_left <= 3'd4;
            end
        end else if (r_state == S_SEND) begin
            if (!w_tx_tick) begin
                r_tx_cnt <= r_tx_cnt - 1'b1;
            end else if (r_tx_bit == 4'd9) begin
                if (r_tx_left != 3'd0) begin
                    r_tx      <= 1'b0;
                    r_tx_cnt  <= BIT_LAST;
                    r_tx_bit  <= '0;
                    r_tx_left <= r_tx_left - 3'd1;
                    r_cmd     <= {8'h00, r_cmd[39:8]};
                end else begin
                    r_tx_cnt <= '0;
                end
            end else begin
                r_tx_cnt <= BIT_LAST;
                r_tx_bit <= r_tx_bit + 4'd1;
                r_tx     <= (r_tx_bit == 4'd8) ? 1'b1 : r_cmd[r_tx_bit[2:0]];
            end
        end
    end

    // Receiver: always running, mid-bit sampling, glitch and framing rejection.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_d    <= 1'b1;
            r_rx_busy <= 1'b0;
            r_rx_bit  <= '0;
            r_rx_cnt  <= '0;
            r_rx_sr   <= '0;
            r_rx_byte <= '0;
            r_rx_done <= 1'b0;
        end else begin
            r_rx_s1   <= i_uart_rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_d    <= r_rx_s2;
            r_rx_done <= 1'b0;
            if (!r_rx_busy) begin
                if (w_rx_fall) begin
                    r_rx_busy <= 1'b1;
                    r_rx_bit  <= '0;
                    r_rx_cnt  <= HALF_LAST;
                end
            end else if (r_rx_cnt != '0) begin
                r_rx_cnt <= r_rx_cnt - 1'b1;
            end else begin
                r_rx_cnt <= BIT_LAST;
                if (r_rx_bit == 4'd0) begin
                    if (r_rx_s2) r_rx_busy <= 1'b0;
                    else         r_rx_bit  <= 4'd1;
                end else if (r_rx_bit <= 4'd8) begin
                    r_rx_sr  <= {r_rx_s2, r_rx_sr[7:1]};
                    r_rx_bit <= r_rx_bit + 4'd1;
                end else begin
                    r_rx_busy <= 1'b0;
                    if (r_rx_s2) begin
                        r_rx_byte <= r_rx_sr;
                        r_rx_done <= 1'b1;
                    end
                end
            end
        end
    end

    // Response assembly; result registers hold until the next response.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rsp_cnt   <= 1'b0;
            r_rsp_hi    <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) r_rsp_cnt <= 1'b0;
            if (r_state == S_WAIT) begin
                if (r_rx_done) begin
                    if (r_rnw) begin
                        if (!r_rsp_cnt) begin
                            r_rsp_hi  <= r_rx_byte;
                            r_rsp_cnt <= 1'b1;
                        end else begin
                            r_rsp_rdata <= {r_rsp_hi, r_rx_byte};
                            r_rsp_err   <= 1'b0;
                        end
                    end else begin
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= (r_rx_byte != 8'h4B);
                    end
                end else if (w_timeout) begin
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b1;
                end
            end
        end
    end

    assign o_uart_tx   = r_tx;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_uart_mem_initiator.sv
// Testbench for uart_mem_initiator: table vectors, randomized transactions against a
// protocol-level reference model, and hand-written glitch / reset / timeout sequences.
module tb_uart_mem_initiator;

    localparam int DF = 4;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_rx;
    logic        uart_tx;
    logic        req_valid;
    logic        req_ready;
    logic        req_rnw;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    uart_mem_initiator #(.DELAY_FRAMES(DF), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_uart_rx   (uart_rx),
        .o_uart_tx   (uart_tx),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_rnw   (req_rnw),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .o_rsp_valid (rsp_valid),
        .o_rsp_rdata (rsp_rdata),
        .o_rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Response monitor
    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } rsp_t;
    rsp_t rsp_q[$];
    int   rsp_long   = 0;
    int   ready_late = 0;
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        if (rsp_valid) rsp_q.push_back('{rsp_rdata, rsp_err});
        if (rsp_valid && prev_valid) rsp_long++;
        if (prev_valid && !req_ready) ready_late++;
        prev_valid = rsp_valid;
    end

    // Reference model of the protocol's response rules
    function automatic void ref_model(input logic rnw, input logic [7:0] b0, input logic [7:0] b1,
                                      output logic [15:0] rd, output logic e);
        if (rnw) begin
            rd = {b0, b1};
            e  = 1'b0;
        end else begin
            rd = 16'h0000;
            e  = (b0 != 8'h4B);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            uart_rx = bits[k];
            repeat (DF) @(posedge clk);
            #1;
        end
    endtask

    // mode 0: normal reply; 1: glitch + framing error before reply; 2: one byte then silence
    task automatic run_txn(input string tag, input logic rnw, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [7:0] b0, input logic [7:0] b1,
                           input int mode, input logic [15:0] exp_rd, input logic exp_err);
        logic [7:0] cmd[5];
        logic [7:0] got[5];
        int         nb;
        int         werr;
        int         rerr;
        int         n;
        logic       e;
        nb = rnw ? 3 : 5;
        cmd[0] = rnw ? 8'h52 : 8'h57;
        cmd[1] = addr[15:8];
        cmd[2] = addr[7:0];
        cmd[3] = wdata[15:8];
        cmd[4] = wdata[7:0];
        werr = 0;
        rerr = 0;
        rsp_q.delete();
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_idle"}, req_ready, 1);
        req_valid = 1'b1;
        req_rnw   = rnw;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        // keep req_valid high with scrambled fields: must be neither re-accepted nor re-captured
        req_rnw   = 1'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        for (int i = 0; i < nb * 10 * DF; i++) begin
            int bi;
            int k;
            int pos;
            @(negedge clk);
            bi  = i / DF;
            k   = bi / 10;
            pos = bi % 10;
            if (pos == 0)      e = 1'b0;
            else if (pos == 9) e = 1'b1;
            else               e = cmd[k][pos-1];
            if (uart_tx !== e) werr++;
            if (req_ready) rerr++;
            if ((i % DF == DF / 2) && pos >= 1 && pos <= 8) got[k][pos-1] = uart_tx;
            if (i == 0) check({tag, "_ready_drop"}, req_ready, 0);
        end
        check({tag, "_tx_wave_errs"}, werr, 0);
        check({tag, "_ready_low_in_send"}, rerr, 0);
        for (int k = 0; k < nb; k++) check($sformatf("%s_tx_byte%0d", tag, k), got[k], cmd[k]);
        req_valid = 1'b0;
        @(negedge clk);
        check({tag, "_tx_idle"}, uart_tx, 1);
        tick();
        repeat ($urandom_range(0, 4)) tick();
        if (mode == 1) begin
            uart_rx = 1'b0;
            tick();
            tick();
            uart_rx = 1'b1;
            repeat (10) tick();
            send_byte(8'h55, 1'b0);
            uart_rx = 1'b1;
            repeat (10) tick();
        end
        if (mode == 2) begin
            send_byte(b0, 1'b1);
            n = 0;
`ifdef UART_INIT_TIMEOUT_EN
            while (rsp_q.size() == 0 && n < TO + 50) begin
                @(negedge clk);
                n++;
            end
            check({tag, "_to_rsp_count"}, rsp_q.size(), 1);
            check({tag, "_to_latency_ok"}, (n >= TO - 5 && n <= TO + 10), 1);
`else
            repeat (10000) @(negedge clk);
            check({tag, "_no_rsp_count"}, rsp_q.size(), 0);
            check({tag, "_no_rsp_ready"}, req_ready, 0);
`endif
        end else begin
            if (rnw) begin
                send_byte(b0, 1'b1);
                check({tag, "_no_early_rsp"}, rsp_q.size(), 0);
                send_byte(b1, 1'b1);
            end else begin
                check({tag, "_no_early_rsp"}, rsp_q.size(), 0);
                send_byte(b0, 1'b1);
            end
            n = 0;
            while (rsp_q.size() == 0 && n < 10) begin
                @(negedge clk);
                n++;
            end
            check({tag, "_rsp_count"}, rsp_q.size(), 1);
        end
        if (rsp_q.size() > 0) begin
            check({tag, "_rdata"}, rsp_q[0].rdata, exp_rd);
            check({tag, "_err"}, rsp_q[0].err, exp_err);
            @(negedge clk);
            check({tag, "_ready_back"}, req_ready, 1);
            check({tag, "_rdata_hold"}, rsp_rdata, exp_rd);
        end
    endtask

    typedef struct {
        logic        rnw;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] m_rd;
        logic        m_err;
        logic [7:0]  rb0;
        logic [7:0]  rb1;
        logic        rnw;

        tbl[0] = '{1'b1, 16'h1234, 16'h0000, 8'hBE, 8'hEF, 16'hBEEF, 1'b0};
        tbl[1] = '{1'b0, 16'h00FF, 16'hA55A, 8'h4B, 8'h00, 16'h0000, 1'b0};
        tbl[2] = '{1'b0, 16'h00FF, 16'hA55A, 8'h00, 8'h00, 16'h0000, 1'b1};
        tbl[3] = '{1'b1, 16'hFFFF, 16'h0000, 8'h00, 8'h00, 16'h0000, 1'b0};
        tbl[4] = '{1'b1, 16'h0000, 16'h0000, 8'hFF, 8'hFF, 16'hFFFF, 1'b0};
        tbl[5] = '{1'b0, 16'h8001, 16'hFFFF, 8'h4A, 8'h00, 16'h0000, 1'b1};

        uart_rx   = 1'b1;
        req_valid = 1'b0;
        req_rnw   = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rst       = 1'b1;
        #1;
        check("reset_tx", uart_tx, 1);
        check("reset_ready", req_ready, 1);
        check("reset_valid", rsp_valid, 0);
        check("reset_rdata", rsp_rdata, 0);
        check("reset_err", rsp_err, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run_txn($sformatf("vec%0d", i), tbl[i].rnw, tbl[i].addr, tbl[i].wdata,
                    tbl[i].b0, tbl[i].b1, 0, tbl[i].exp_rd, tbl[i].exp_err);

        for (int i = 0; i < 8; i++) begin
            rnw = 1'($urandom);
            rb0 = (!rnw && ($urandom_range(0, 1) == 1)) ? 8'h4B : 8'($urandom);
            rb1 = 8'($urandom);
            ref_model(rnw, rb0, rb1, m_rd, m_err);
            run_txn($sformatf("rnd%0d", i), rnw, 16'($urandom), 16'($urandom), rb0, rb1, 0, m_rd, m_err);
        end

        run_txn("glitch", 1'b1, 16'h4321, 16'h0000, 8'h11, 8'h22, 1, 16'h1122, 1'b0);

        // reset during byte 2 (address low byte = 0x00) of a write
        rsp_q.delete();
        @(negedge clk);
        req_valid = 1'b1;
        req_rnw   = 1'b0;
        req_addr  = 16'h1200;
        req_wdata = 16'h3456;
        tick();
        req_valid = 1'b0;
        repeat (2 * 10 * DF + 4 * DF + 2) @(negedge clk);
        check("rst_pre_tx", uart_tx, 0);
        check("rst_pre_ready", req_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_tx", uart_tx, 1);
        check("rst_mid_ready", req_ready, 1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_no_rsp", rsp_q.size(), 0);
        run_txn("post_rst", 1'b1, 16'hCAFE, 16'h0000, 8'h5A, 8'hA5, 0, 16'h5AA5, 1'b0);

        run_txn("stall", 1'b1, 16'h0042, 16'h0000, 8'h77, 8'h00, 2, 16'h0000, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_txn("recover", 1'b0, 16'h0101, 16'h0202, 8'h4B, 8'h00, 0, 16'h0000, 1'b0);

        check("rsp_single_cycle", rsp_long, 0);
        check("ready_after_pulse", ready_late, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_mem_initiator.md
# uart_mem_initiator

Host-side UART initiator for the memory-override command protocol. It accepts one memory request at a time on a valid/ready port and serialises it as a command frame on `uart_tx`. It then deserialises the responder's reply from `uart_rx` and returns read data or a write acknowledgement on a one-cycle response strobe. It lets one FPGA load, inspect or debug another board's memory over a single UART link.

## Interface
- `DELAY_FRAMES`, 234: clock cycles per UART bit (27 MHz / 115200 baud); must be ≥ 4.
- `TIMEOUT_CYCLES`, 2700000: response timeout in clock cycles. Only used when `UART_INIT_TIMEOUT_EN` is defined.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `uart_rx`  in  1  serial line from responder; idle high; asynchronous to `clk`.
- `uart_tx`  out  1  serial line to responder; idle high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  initiator idle; a request is accepted on `req_valid && req_ready`.
- `req_rnw`  in  1  1 = read, 0 = write.
- `req_addr`  in  16  word address.
- `req_wdata`  in  16  write data; ignored for reads.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_rdata`  out  16  read data; 0 for writes and errors.
- `rsp_err`  out  1  response error flag; qualified by `rsp_valid`.

## Operation
- Line format:
  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - Each bit lasts exactly `DELAY_FRAMES` cycles.
  - Consecutive command bytes are sent back-to-back, with no idle gap.
- Command frame, bytes sent in this order:
  - Read: 0x52, addr[15:8], addr[7:0].
  - Write: 0x57, addr[15:8], addr[7:0], wdata[15:8], wdata[7:0].
- Response frame:
  - Read: data[15:8], data[7:0].
  - Write: one byte, 0x4B.
- Request capture: address, data and read/write flag are latched at acceptance. Later changes on the `req_*` inputs have no effect.
- Receiver:
  - `uart_rx` passes through a 2-flop synchroniser.
  - A falling edge while the receiver is idle starts a byte.
  - The start bit is re-checked at `DELAY_FRAMES/2`. If it is high, the edge is treated as a glitch and the receiver returns to idle.
  - Data bits are sampled every `DELAY_FRAMES` after that point, then the stop bit.
  - A stop bit of 0 is a framing error: the byte is dropped and the receiver returns to idle.
- State machine:
  - IDLE: `req_ready`=1; received bytes are discarded. On acceptance, go to SEND.
  - SEND: shift out the 3 or 5 command bytes. After the final stop bit completes, go to WAIT.
  - WAIT: collect response bytes.
    - Read: after 2 bytes, go to DONE with `rsp_rdata` = {byte0, byte1}.
    - Write: after 1 byte, go to DONE; `rsp_err` = (byte != 0x4B).
  - DONE: assert `rsp_valid` for one cycle, then go to IDLE.
- Bytes arriving during SEND are discarded. The receiver runs continuously, so a byte already in flight when WAIT is entered is kept.
- No request queueing. `req_valid` held high during a transaction is accepted again only after the return to IDLE.

## Timing
- Reset values:
  - `uart_tx`=1, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - State is IDLE; all counters are 0.
- Reset mid-transaction: reset takes effect immediately and truncates any frame in progress (`uart_tx` goes high at once). The responder sees a framing error; no response is produced.
- `req_ready` drops in the cycle after acceptance. The start bit of byte 0 appears on `uart_tx` in that same cycle.
- Command duration: 30 × `DELAY_FRAMES` cycles for a read, 50 × `DELAY_FRAMES` for a write, measured from the first start-bit cycle.
- A response byte counts as received in the cycle after its stop-bit sample.
- `rsp_valid` pulses in the cycle after the final response byte is received. `req_ready` returns high in the cycle after the pulse.
- `rsp_rdata` and `rsp_err` hold their values until the next `rsp_valid`.
- Back-to-back transactions: the earliest next acceptance is in the cycle `req_ready` rises.

## Configuration
- Macro `UART_INIT_TIMEOUT_EN`.
- Defined:
  - A counter starts on entry to WAIT and clears on each received byte.
  - If it reaches `TIMEOUT_CYCLES`, go to DONE with `rsp_err`=1 and `rsp_rdata`=0. A partially received read word is discarded.
- Undefined:
  - No counter is built and WAIT has no exit other than a completed response.
  - `rsp_err` is set only by a bad write acknowledgement.

## Test plan
- `DELAY_FRAMES`=4 throughout.
- Read request, addr 0x1234: `uart_tx` carries 0x52, 0x12, 0x34 (120 cycles). Bench replies 0xBE, 0xEF → `rsp_valid` pulse with `rsp_rdata`=0xBEEF, `rsp_err`=0.
- Write, addr 0x00FF, data 0xA55A: `uart_tx` carries 0x57, 0x00, 0xFF, 0xA5, 0x5A (200 cycles). Bench replies 0x4B → `rsp_err`=0, `rsp_rdata`=0. Repeat with reply 0x00 → `rsp_err`=1.
- 2-cycle low glitch on `uart_rx` in WAIT, then a bad-stop-bit byte, then valid 0x11, 0x22 → `rsp_rdata`=0x1122 (glitch and framing error ignored).
- Assert `rst` during byte 2 of a write → `uart_tx`=1 and `req_ready`=1 immediately. A new read then completes normally.
- With `UART_INIT_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100: read, bench sends one byte then nothing → `rsp_valid` with `rsp_err`=1, `rsp_rdata`=0. Without the macro: no response after 10000 cycles and `req_ready` stays 0.
